// File: rtl/softex_pkg.sv
// Shared types for the softmax slot cache: slot layout, request/update ops,
// and the response FSM state encoding.
package softex_pkg;

  localparam int unsigned SLOT_ADDR_BITS  = 3;
  localparam int unsigned N_SLOTS_DEFAULT = 4;

  typedef enum logic {
    SLOT_ALLOC = 1'b0,
    SLOT_LOAD  = 1'b1
  } slot_req_kind_e;

  typedef enum logic {
    SLOT_UPDATE = 1'b0,
    SLOT_FREE   = 1'b1
  } slot_upd_kind_e;

  typedef enum logic {
    RSP_IDLE = 1'b0,
    RSP_RESP = 1'b1
  } rsp_state_e;

  typedef struct packed {
    logic [15:0] maximum;
    logic [31:0] denominator;
    logic        valid;
  } slot_t;

  typedef struct packed {
    slot_req_kind_e            op;
    logic [SLOT_ADDR_BITS-1:0] addr;
  } slot_req_op_t;

  typedef struct packed {
    slot_upd_kind_e            op;
    logic [SLOT_ADDR_BITS-1:0] addr;
    logic [15:0]               maximum;
    logic [31:0]               denominator;
  } slot_update_op_t;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter. MODE=0 counts trailing zeros, MODE=1 leading
// zeros; empty_o flags an all-zero input.
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  always_comb begin
    cnt_o = '0;
    if (!MODE) begin
      // Scan downwards so the lowest set bit wins.
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
      end
    end
    empty_o = ~|in_i;
  end

endmodule

// File: rtl/softex_slot_cache.sv
// Small flop-based cache of softmax running {maximum, denominator} slots with
// ALLOC/LOAD requests (registered response) and fire-and-forget UPDATE/FREE.
module softex_slot_cache
  import softex_pkg::*;
#(
  parameter int unsigned N_SLOTS = N_SLOTS_DEFAULT,
  parameter logic [15:0] MAX_RST = 16'hFF80
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  slot_req_op_t              req_op_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [SLOT_ADDR_BITS-1:0] rsp_addr_o,
  output slot_t                     rsp_slot_o,
  output logic                      rsp_error_o,
  input  logic                      update_valid_i,
  input  slot_update_op_t           update_op_i,
  output logic [SLOT_ADDR_BITS:0]   n_free_o,
  output rsp_state_e                dbg_state_o
);

  localparam int unsigned CNT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam logic [SLOT_ADDR_BITS:0] ONE      = (SLOT_ADDR_BITS + 1)'(1);
  localparam logic [SLOT_ADDR_BITS:0] N_SLOTS_W = (SLOT_ADDR_BITS + 1)'(N_SLOTS);
  localparam slot_t ALLOC_SLOT = '{maximum: MAX_RST, denominator: 32'h0, valid: 1'b1};

  slot_t                     slots_q   [N_SLOTS];
  slot_t                     slots_d   [N_SLOTS];
  slot_t                     slots_upd [N_SLOTS];
  rsp_state_e                state_q, state_d;
  logic [SLOT_ADDR_BITS-1:0] rsp_addr_q, rsp_addr_d;
  slot_t                     rsp_slot_q, rsp_slot_d;
  logic                      rsp_error_q, rsp_error_d;
  logic [SLOT_ADDR_BITS:0]   n_free_q, n_free_d;

  logic [N_SLOTS-1:0]        free_vec;
  logic [CNT_W-1:0]          lzc_cnt;
  logic                      lzc_empty;
  logic [SLOT_ADDR_BITS-1:0] alloc_idx;
  logic                      req_fire, alloc_ok, free_ok;
  slot_t                     load_slot;

  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) free_vec[i] = !slots_q[i].valid;
  end

  // Searches pre-update state, so a slot freed this cycle is not yet eligible.
  lzc #(
    .WIDTH    (N_SLOTS),
    .MODE     (1'b0),
    .CNT_WIDTH(CNT_W)
  ) i_lzc (
    .in_i   (free_vec),
    .cnt_o  (lzc_cnt),
    .empty_o(lzc_empty)
  );

  // Handshake: a request transfers on req_valid_i && req_ready_o; a response
  // transfers on rsp_valid_o && rsp_ready_i and is held stable until then.
  // req_ready_o is high whenever the response register is empty or draining.
  always_comb begin
    req_ready_o = (state_q == RSP_IDLE) || rsp_ready_i;
    req_fire    = req_valid_i && req_ready_o;
    alloc_idx   = SLOT_ADDR_BITS'(lzc_cnt);
    alloc_ok    = req_fire && (req_op_i.op == SLOT_ALLOC) && !lzc_empty;
    free_ok     = 1'b0;

    // Updates land first so a same-cycle LOAD sees the written value.
    for (int i = 0; i < N_SLOTS; i++) begin
      slots_upd[i] = slots_q[i];
      if (update_valid_i && (update_op_i.addr == SLOT_ADDR_BITS'(i)) && slots_q[i].valid) begin
        if (update_op_i.op == SLOT_FREE) begin
          slots_upd[i].valid = 1'b0;
          free_ok            = 1'b1;
        end else begin
          slots_upd[i].maximum     = update_op_i.maximum;
          slots_upd[i].denominator = update_op_i.denominator;
        end
      end
    end

    load_slot = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (req_op_i.addr == SLOT_ADDR_BITS'(i)) load_slot = slots_upd[i];
    end

    for (int i = 0; i < N_SLOTS; i++) begin
      slots_d[i] = slots_upd[i];
      if (alloc_ok && (alloc_idx == SLOT_ADDR_BITS'(i))) slots_d[i] = ALLOC_SLOT;
    end

    n_free_d = n_free_q;
    if (alloc_ok) n_free_d = n_free_d - ONE;
    if (free_ok)  n_free_d = n_free_d + ONE;

    state_d     = state_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_slot_d  = rsp_slot_q;
    rsp_error_d = rsp_error_q;
    if (req_fire) begin
      state_d = RSP_RESP;
      if (req_op_i.op == SLOT_ALLOC) begin
        rsp_error_d = lzc_empty;
        rsp_addr_d  = lzc_empty ? '0 : alloc_idx;
        rsp_slot_d  = lzc_empty ? '0 : ALLOC_SLOT;
      end else begin
        rsp_error_d = !load_slot.valid;
        rsp_addr_d  = req_op_i.addr;
        rsp_slot_d  = load_slot.valid ? load_slot : '0;
      end
    end else if (rsp_ready_i) begin
      state_d = RSP_IDLE;
    end

    if (clear_i) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        slots_d[i]       = slots_q[i];
        slots_d[i].valid = 1'b0;
      end
      n_free_d    = N_SLOTS_W;
      state_d     = RSP_IDLE;
      rsp_addr_d  = '0;
      rsp_slot_d  = '0;
      rsp_error_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_SLOTS; i++) slots_q[i] <= '0;
      state_q     <= RSP_IDLE;
      rsp_addr_q  <= '0;
      rsp_slot_q  <= '0;
      rsp_error_q <= 1'b0;
      n_free_q    <= N_SLOTS_W;
    end else begin
      for (int i = 0; i < N_SLOTS; i++) slots_q[i] <= slots_d[i];
      state_q     <= state_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_slot_q  <= rsp_slot_d;
      rsp_error_q <= rsp_error_d;
      n_free_q    <= n_free_d;
    end
  end

  assign rsp_valid_o = (state_q == RSP_RESP);
  assign rsp_addr_o  = rsp_addr_q;
  assign rsp_slot_o  = rsp_slot_q;
  assign rsp_error_o = rsp_error_q;
  assign n_free_o    = n_free_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/softex_slot_cache.md
SOFTEX_SLOT_CACHE -- requirements
Module: softex_slot_cache

Interface
REQ-001 SHALL have parameter N_SLOTS, default 4: number of slot entries; 1 <= N_SLOTS <= 2**SLOT_ADDR_BITS.
REQ-002 SHALL have parameter MAX_RST, default 16'hFF80 (FP16ALT -inf): maximum value written into a newly allocated slot.
REQ-003 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port clear_i, input, 1: synchronous clear of all slots.
REQ-006 SHALL have port req_valid_i, input, 1: request valid.
REQ-007 SHALL have port req_ready_o, output, 1: request accepted when req_valid_i && req_ready_o.
REQ-008 SHALL have port req_op_i, input, slot_req_op_t: op ALLOC/LOAD plus addr.
REQ-009 SHALL have port rsp_valid_o, output, 1: response valid.
REQ-010 SHALL have port rsp_ready_i, input, 1: response consumed when rsp_valid_o && rsp_ready_i.
REQ-011 SHALL have port rsp_addr_o, output, SLOT_ADDR_BITS: allocated or loaded slot index.
REQ-012 SHALL have port rsp_slot_o, output, slot_t: slot contents.
REQ-013 SHALL have port rsp_error_o, output, 1: request failed.
REQ-014 SHALL have port update_valid_i, input, 1: update strobe; always accepted, no ready.
REQ-015 SHALL have port update_op_i, input, slot_update_op_t: op UPDATE/FREE, addr, maximum, denominator.
REQ-016 SHALL have port n_free_o, output, SLOT_ADDR_BITS+1: count of slots with valid=0.

Function
REQ-017 SHALL use a two-state response FSM: IDLE (rsp_valid_o=0) and RESP (rsp_valid_o=1).
REQ-018 SHALL drive req_ready_o = !rsp_valid_o || rsp_ready_i, so back-to-back requests run at one per cycle.
REQ-019 SHALL register the response: a request accepted in cycle N gives rsp_valid_o=1 in cycle N+1.
REQ-020 SHALL hold rsp_* stable while rsp_valid_o=1 && !rsp_ready_i.
REQ-021 ALLOC SHALL pick the lowest-index slot with valid=0 and write {MAX_RST, 32'h0, valid=1} into it.
REQ-022 ALLOC SHALL return the chosen index on rsp_addr_o and the written slot contents on rsp_slot_o.
REQ-023 ALLOC with no free slot SHALL return rsp_error_o=1 and rsp_addr_o=0, with no state change.
REQ-024 LOAD SHALL return the contents of slot addr.
REQ-025 LOAD of a slot with valid=0, or with addr >= N_SLOTS, SHALL return rsp_error_o=1, rsp_slot_o='0, rsp_addr_o=addr.
REQ-026 UPDATE SHALL write maximum and denominator to slot addr only if that slot has valid=1.
REQ-027 UPDATE to a slot with valid=0, or with addr >= N_SLOTS, SHALL be ignored.
REQ-028 FREE SHALL clear the valid bit of slot addr; freeing a slot that is already free is a no-op.
REQ-029 Update and request in the same cycle, same addr: a LOAD SHALL return the post-update value (write-first bypass), and a LOAD of a slot being freed SHALL error.
REQ-030 A slot freed in cycle N SHALL NOT be eligible for an ALLOC accepted in cycle N; it becomes eligible in cycle N+1.
REQ-031 clear_i SHALL set every valid bit to 0 and return to IDLE, dropping any pending response; clear_i overrides a request or update in the same cycle.
REQ-032 n_free_o SHALL be registered and reflect state after the previous edge; it counts down on each successful ALLOC and up on each FREE of a valid slot.

Reset
REQ-033 On rst_i, all slots SHALL become {maximum='0, denominator='0, valid=0}.
REQ-034 On rst_i, the FSM SHALL go to IDLE, with rsp_valid_o=0, rsp_addr_o=0, rsp_slot_o='0, rsp_error_o=0, and n_free_o=N_SLOTS.
REQ-035 req_ready_o SHALL be 1 during and after reset; reset mid-transaction SHALL discard the outstanding response.

Structure
REQ-036 slot_t, slot_req_op_t, slot_update_op_t, SLOT_ADDR_BITS and a new constant N_SLOTS_DEFAULT SHALL live in softex_pkg.
REQ-037 Free-slot search SHALL use the common_cells lzc sub-module (trailing-zero mode) on the inverted valid vector; its empty flag drives the ALLOC error.
REQ-038 Slot storage SHALL be flip-flops (no SRAM macro), with async reset per REQ-033.

Verification
REQ-039 Reset, then 4 ALLOCs back-to-back with rsp_ready_i=1 -> rsp_addr_o=0,1,2,3 on consecutive cycles; each rsp_slot_o={FF80,0,1}; n_free_o ends at 0.
REQ-040 5th ALLOC -> rsp_error_o=1, rsp_addr_o=0; then FREE addr 2 and ALLOC one cycle later -> rsp_addr_o=2.
REQ-041 UPDATE addr 1 {max=3F80, den=40000000} in the same cycle as LOAD addr 1 -> response {3F80,40000000,1}, error=0.
REQ-042 LOAD addr 1 with rsp_ready_i=0 for 3 cycles -> rsp_* stable and req_ready_o=0; ready high -> consumed next edge.
REQ-043 LOAD addr 7 with N_SLOTS=4 -> rsp_error_o=1; UPDATE addr 3 while slot 3 is free -> later LOAD addr 3 gives error=1.
REQ-044 rst_i pulsed while in RESP -> rsp_valid_o=0 immediately (async), n_free_o=4; clear_i with all slots valid -> n_free_o=4 on the next cycle.
